prime_checker_core: RTL and testbench

Parametrised divisor-count / primality engine, successor to the 8-bit fixed-path prime datapath. Accepts an unsigned `W`-bit operand with a start/done handshake. Counts the divisors of the operand by repeated subtraction with a descending trial divisor, and reports `is_prime` (divisor count == 2) together with its complement. Adds an early-exit mode that terminates on the third divisor. Sits between the operand register file and the output display/LED path of the processor.

---
 rtl/prime_pkg.sv | 14 +
 rtl/prime_checker_core_if.sv | 26 ++
 rtl/prime_datapath.sv | 74 +++++++
 rtl/prime_checker_core.sv | 126 ++++++++++++
 tb/tb_prime_checker_core.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/prime_pkg.sv
// Shared types and constants for the divisor-count / primality engine.
package prime_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    NEXT,
    DONE
  } prime_state_t;

  localparam int PRIME_DIV_COUNT = 2;
  localparam int EARLY_LIMIT     = 3;

endpackage

// File: rtl/prime_checker_core_if.sv
// Start/done handshake, operand and result bundle of the primality engine.
interface prime_checker_core_if #(
  parameter int W = 8
);

  logic         start;
  logic [W-1:0] n;
  logic         early_exit;
  logic         busy;
  logic         done;
  logic         is_prime;
  logic         is_prime_n;
  logic [W-1:0] div_count;
  logic [W-1:0] n_q;

  modport master (
    output start, n, early_exit,
    input  busy, done, is_prime, is_prime_n, div_count, n_q
  );

  modport slave (
    input  start, n, early_exit,
    output busy, done, is_prime, is_prime_n, div_count, n_q
  );

endinterface

// File: rtl/prime_datapath.sv
// Operand, remainder, trial-divisor and count registers with the
// compare/subtract logic, steered by enables from the controlling FSM.
module prime_datapath
  import prime_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         sub_en,
  input  logic         inc_en,
  input  logic         next_en,
  input  logic [W-1:0] n_in,
  output logic [W-1:0] n_val,
  output logic [W-1:0] c_val,
  output logic         n_small,
  output logic         a_gt_k,
  output logic         a_eq_k,
  output logic         k_is_one
);

  logic [W-1:0] n_q, n_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] k_q, k_d;
  logic [W-1:0] c_q, c_d;

  assign n_small  = (n_in < W'(2));
  assign a_gt_k   = (a_q > k_q);
  assign a_eq_k   = (a_q == k_q);
  assign k_is_one = (k_q == W'(1));
  assign n_val    = n_q;
  assign c_val    = c_q;

  // Operands 0 and 1 skip the loop, so their count is the operand itself.
  always_comb begin
    n_d = n_q;
    a_d = a_q;
    k_d = k_q;
    c_d = c_q;
    if (load) begin
      n_d = n_in;
      a_d = n_in;
      k_d = n_in;
      c_d = n_small ? n_in : '0;
    end else begin
      if (sub_en) begin
        a_d = a_q - k_q;
      end
      if (inc_en) begin
        c_d = c_q + W'(1);
      end
      if (next_en) begin
        k_d = k_q - W'(1);
        a_d = n_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_q <= '0;
      a_q <= '0;
      k_q <= '0;
      c_q <= '0;
    end else begin
      n_q <= n_d;
      a_q <= a_d;
      k_q <= k_d;
      c_q <= c_d;
    end
  end

endmodule

// File: rtl/prime_checker_core.sv
// Divisor-count / primality engine: FSM sequencing a repeated-subtraction
// datapath with a descending trial divisor and optional early exit.
module prime_checker_core
  import prime_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  prime_checker_core_if.slave   bus
);

  prime_state_t state_q, state_d;
  logic         early_q, early_d;
  logic         is_prime_q, is_prime_d;
  logic         is_prime_n_q, is_prime_n_d;
  logic [W-1:0] div_count_q, div_count_d;

  logic         load, sub_en, inc_en, next_en;
  logic         finish;
  logic [W-1:0] final_cnt;
  logic [W-1:0] n_val, c_val;
  logic         n_small, a_gt_k, a_eq_k, k_is_one;

  prime_datapath #(.W(W)) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .sub_en   (sub_en),
    .inc_en   (inc_en),
    .next_en  (next_en),
    .n_in     (bus.n),
    .n_val    (n_val),
    .c_val    (c_val),
    .n_small  (n_small),
    .a_gt_k   (a_gt_k),
    .a_eq_k   (a_eq_k),
    .k_is_one (k_is_one)
  );

  // Results are registered on the edge entering DONE so they are valid with done.
  always_comb begin
    state_d      = state_q;
    early_d      = early_q;
    is_prime_d   = is_prime_q;
    is_prime_n_d = is_prime_n_q;
    div_count_d  = div_count_q;
    load         = 1'b0;
    sub_en       = 1'b0;
    inc_en       = 1'b0;
    next_en      = 1'b0;
    finish       = 1'b0;
    final_cnt    = c_val;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          early_d = bus.early_exit;
          if (n_small) begin
            finish    = 1'b1;
            final_cnt = bus.n;
            state_d   = DONE;
          end else begin
            state_d = SUB;
          end
        end
      end
      SUB: begin
        if (a_gt_k) begin
          sub_en = 1'b1;
        end else if (a_eq_k) begin
          inc_en  = 1'b1;
          state_d = NEXT;
        end else begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (k_is_one || (early_q && (c_val >= W'(EARLY_LIMIT)))) begin
          finish  = 1'b1;
          state_d = DONE;
        end else begin
          next_en = 1'b1;
          state_d = SUB;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (finish) begin
      div_count_d  = final_cnt;
      is_prime_d   = (final_cnt == W'(PRIME_DIV_COUNT));
      is_prime_n_d = (final_cnt != W'(PRIME_DIV_COUNT));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      early_q      <= 1'b0;
      is_prime_q   <= 1'b0;
      is_prime_n_q <= 1'b1;
      div_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      early_q      <= early_d;
      is_prime_q   <= is_prime_d;
      is_prime_n_q <= is_prime_n_d;
      div_count_q  <= div_count_d;
    end
  end

  assign bus.busy       = (state_q == SUB) || (state_q == NEXT);
  assign bus.done       = (state_q == DONE);
  assign bus.is_prime   = is_prime_q;
  assign bus.is_prime_n = is_prime_n_q;
  assign bus.div_count  = div_count_q;
  assign bus.n_q        = n_val;

endmodule

// File: tb/tb_prime_checker_core.sv
// Bench for prime_checker_core: W=8 and W=16 instances driven in lockstep and
// checked against a divisor-counting reference model.
module tb_prime_checker_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prime_checker_core_if #(.W(8))  bus8 ();
  prime_checker_core_if #(.W(16)) bus16 ();

  prime_checker_core #(.W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  prime_checker_core #(.W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] n;
    logic        early;
    int          exp_cnt;
    logic        exp_prime;
    int          exp_lat;
    bit          noise;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic driveInputs(input logic s, input logic [15:0] nv, input logic e);
    bus8.start       = s;
    bus8.n           = nv[7:0];
    bus8.early_exit  = e;
    bus16.start      = s;
    bus16.n          = nv;
    bus16.early_exit = e;
  endtask

  // Divisors are tried from N downward; each trial costs its SUB compares plus one NEXT.
  function automatic void refModel(input int nv, input bit early, output int cnt, output int lat);
    cnt = 0;
    lat = 1;
    if (nv < 2) begin
      cnt = nv;
      return;
    end
    for (int k = nv; k >= 1; k--) begin
      lat += (nv - 1) / k + 2;
      if (nv % k == 0) cnt++;
      if (k == 1) break;
      if (early && cnt >= 3) break;
    end
  endfunction

  task automatic applyStimulus(input logic [15:0] nv, input logic e, input bit noise,
                               output int lat8, output int lat16);
    @(posedge clk); #1;
    driveInputs(1'b1, nv, e);
    @(posedge clk); #1;
    driveInputs(1'b0, nv, e);
    lat8 = 0;
    lat16 = 0;
    for (int cyc = 1; cyc <= 6000; cyc++) begin
      if (bus8.done && lat8 == 0) lat8 = cyc;
      if (bus16.done && lat16 == 0) lat16 = cyc;
      if (lat8 != 0 && lat16 != 0) break;
      if (noise && bus8.busy && bus16.busy && (cyc % 7 == 3))
        driveInputs(1'b1, 16'($urandom_range(0, 255)), 1'b1);
      else
        driveInputs(1'b0, nv, e);
      @(posedge clk); #1;
    end
    driveInputs(1'b0, nv, e);
    if (lat8 == 0) checkOutput("timeout_w8", 32'(0), 32'(1));
    if (lat16 == 0) checkOutput("timeout_w16", 32'(0), 32'(1));
  endtask

  task automatic runCase(input string name, input logic [15:0] nv, input logic e,
                         input int exp_cnt, input logic exp_prime, input int exp_lat,
                         input bit noise, output int lat_o);
    int mc, ml, l8, l16;
    refModel(int'(nv), e, mc, ml);
    applyStimulus(nv, e, noise, l8, l16);
    checkOutput({name, "_cnt_w8"},    32'(bus8.div_count),   32'(exp_cnt));
    checkOutput({name, "_cnt_w16"},   32'(bus16.div_count),  32'(exp_cnt));
    checkOutput({name, "_prime_w8"},  32'(bus8.is_prime),    32'(exp_prime));
    checkOutput({name, "_prime_w16"}, 32'(bus16.is_prime),   32'(exp_prime));
    checkOutput({name, "_primen_w8"}, 32'(bus8.is_prime_n),  32'(!exp_prime));
    checkOutput({name, "_primen_w16"},32'(bus16.is_prime_n), 32'(!exp_prime));
    checkOutput({name, "_nq_w8"},     32'(bus8.n_q),         32'(nv[7:0]));
    checkOutput({name, "_nq_w16"},    32'(bus16.n_q),        32'(nv));
    checkOutput({name, "_busy_w8"},   32'(bus8.busy),        32'(0));
    checkOutput({name, "_lat_w8"},    32'(l8),               32'(ml));
    checkOutput({name, "_lat_w16"},   32'(l16),              32'(ml));
    if (exp_lat >= 0) checkOutput({name, "_lat_abs"}, 32'(l8), 32'(exp_lat));
    lat_o = l8;
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_busy"},   32'({bus8.busy, bus16.busy}),             32'(0));
    checkOutput({name, "_done"},   32'({bus8.done, bus16.done}),             32'(0));
    checkOutput({name, "_prime"},  32'({bus8.is_prime, bus16.is_prime}),     32'(0));
    checkOutput({name, "_primen"}, 32'({bus8.is_prime_n, bus16.is_prime_n}), 32'(3));
    checkOutput({name, "_cnt"},    32'(bus8.div_count) + 32'(bus16.div_count), 32'(0));
    checkOutput({name, "_nq"},     32'(bus8.n_q) + 32'(bus16.n_q),           32'(0));
  endtask

  initial begin
    int lat, lat_full12, lat_early12, mc, ml, stray, unstable;
    logic [15:0] rn;
    logic re;
    bit seen;

    vecs[0] = '{n: 16'd5,   early: 1'b0, exp_cnt: 2, exp_prime: 1'b1, exp_lat: 19, noise: 1'b0};
    vecs[1] = '{n: 16'd0,   early: 1'b0, exp_cnt: 0, exp_prime: 1'b0, exp_lat: 1,  noise: 1'b0};
    vecs[2] = '{n: 16'd1,   early: 1'b0, exp_cnt: 1, exp_prime: 1'b0, exp_lat: 1,  noise: 1'b0};
    vecs[3] = '{n: 16'd2,   early: 1'b0, exp_cnt: 2, exp_prime: 1'b1, exp_lat: 6,  noise: 1'b0};
    vecs[4] = '{n: 16'd4,   early: 1'b1, exp_cnt: 3, exp_prime: 1'b0, exp_lat: -1, noise: 1'b0};
    vecs[5] = '{n: 16'd12,  early: 1'b0, exp_cnt: 6, exp_prime: 1'b0, exp_lat: -1, noise: 1'b0};
    vecs[6] = '{n: 16'd12,  early: 1'b1, exp_cnt: 3, exp_prime: 1'b0, exp_lat: -1, noise: 1'b0};
    vecs[7] = '{n: 16'd251, early: 1'b0, exp_cnt: 2, exp_prime: 1'b1, exp_lat: -1, noise: 1'b1};

    driveInputs(1'b0, 16'd0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    rst_n = 1'b1;

    lat_full12 = 0;
    lat_early12 = 0;
    for (int i = 0; i < 8; i++) begin
      runCase($sformatf("vec%0d", i), vecs[i].n, vecs[i].early, vecs[i].exp_cnt,
              vecs[i].exp_prime, vecs[i].exp_lat, vecs[i].noise, lat);
      if (i == 5) lat_full12 = lat;
      if (i == 6) lat_early12 = lat;
    end
    checkOutput("early_exit_faster", 32'(lat_early12 < lat_full12), 32'(1));

    // Abort a long run with reset and make sure no done ever follows.
    @(posedge clk); #1;
    driveInputs(1'b1, 16'd97, 1'b0);
    @(posedge clk); #1;
    driveInputs(1'b0, 16'd97, 1'b0);
    repeat (20) begin
      @(posedge clk); #1;
    end
    checkOutput("pre_reset_busy", 32'({bus8.busy, bus16.busy}), 32'(3));
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkResetState("midrun_reset");
    rst_n = 1'b1;
    stray = 0;
    repeat (400) begin
      @(posedge clk); #1;
      if (bus8.done || bus16.done || bus8.busy || bus16.busy) stray++;
    end
    checkOutput("no_done_after_reset", 32'(stray), 32'(0));
    runCase("after_reset7", 16'd7, 1'b0, 2, 1'b1, -1, 1'b0, lat);

    // start held high across two runs: N=7 then N=9.
    @(posedge clk); #1;
    driveInputs(1'b1, 16'd7, 1'b0);
    @(posedge clk); #1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (bus8.done && bus16.done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("b2b_first_done", 32'(seen), 32'(1));
    checkOutput("b2b_first_cnt", 32'(bus8.div_count) + 32'(bus16.div_count), 32'(4));
    checkOutput("b2b_first_prime", 32'({bus8.is_prime, bus16.is_prime}), 32'(3));
    driveInputs(1'b1, 16'd9, 1'b0);
    @(posedge clk); #1;
    checkOutput("b2b_idle_gap", 32'({bus8.busy, bus16.busy, bus8.done, bus16.done}), 32'(0));
    @(posedge clk); #1;
    checkOutput("b2b_second_accept", 32'({bus8.busy, bus16.busy}), 32'(3));
    checkOutput("b2b_second_nq", 32'(bus16.n_q), 32'(9));
    driveInputs(1'b0, 16'd9, 1'b0);
    seen = 1'b0;
    unstable = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (bus8.done && bus16.done) begin
        seen = 1'b1;
        break;
      end
      if (bus8.is_prime !== 1'b1 || bus16.is_prime !== 1'b1 ||
          bus8.div_count !== 8'd2 || bus16.div_count !== 16'd2) unstable++;
      @(posedge clk); #1;
    end
    checkOutput("b2b_second_done", 32'(seen), 32'(1));
    checkOutput("b2b_hold_first", 32'(unstable), 32'(0));
    checkOutput("b2b_second_cnt_w8", 32'(bus8.div_count), 32'(3));
    checkOutput("b2b_second_cnt_w16", 32'(bus16.div_count), 32'(3));
    checkOutput("b2b_second_prime", 32'({bus8.is_prime, bus16.is_prime}), 32'(0));
    checkOutput("b2b_second_primen", 32'({bus8.is_prime_n, bus16.is_prime_n}), 32'(3));

    for (int i = 0; i < 10; i++) begin
      rn = 16'($urandom_range(0, 180));
      re = 1'($urandom_range(0, 1));
      refModel(int'(rn), re, mc, ml);
      runCase($sformatf("rand%0d_n%0d_e%0d", i, rn, re), rn, re, mc, (mc == 2), -1, 1'b0, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
